// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, scan FSM state encoding and the matrix map.
// Imported by the scan encoder and by the calculator mode FSM that consumes key_in.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_ADD   = 4'd10;
  localparam key_code_t KEY_SUB   = 4'd11;
  localparam key_code_t KEY_MUL   = 4'd12;
  localparam key_code_t KEY_ENTER = 4'd13;
  localparam key_code_t KEY_STAR  = 4'd14;
  localparam key_code_t KEY_HASH  = 4'd15;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  // Physical layout: r0: 1 2 3 + | r1: 4 5 6 - | r2: 7 8 9 * | r3: *-key 0 # enter
  function automatic key_code_t keymap(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    code = '0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_MUL;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_ENTER;
      default:  code = '0;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several rows are pulled down together.
  function automatic logic [1:0] low_row_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    if      (!rows[0]) idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else if (!rows[3]) idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    case (cols)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row inputs.
// Resets to all-ones so an idle (pulled-up) keypad is assumed until real samples arrive.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: column rotation, press/release debounce and key encoding.
// Produces key_in/key_valid/key_down for the calculator mode FSM.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_in,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LIMIT = DW'(DEBOUNCE_CNT);

  logic [3:0]    rows_s;
  logic [SW-1:0] slot;
  logic [1:0]    state;
  logic [1:0]    cand_row;
  logic [1:0]    cand_col;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] rel_cnt;

  logic          sample;
  logic          any_low;
  logic          cand_low;
  logic [DW-1:0] deb_next;
  logic [DW-1:0] rel_next;
  logic [3:0]    col_rot;
  logic [1:0]    hit_row;
  logic [1:0]    hit_col;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rows_s)
  );

  // Counters saturate at the limit so a long hold never wraps back to an accept.
  always_comb begin
    sample   = (slot == SLOT_LAST);
    any_low  = (rows_s != 4'hF);
    cand_low = ~rows_s[cand_row];
    deb_next = (deb_cnt == DEB_LIMIT) ? deb_cnt : deb_cnt + 1'b1;
    rel_next = cand_low ? '0 : ((rel_cnt == DEB_LIMIT) ? rel_cnt : rel_cnt + 1'b1);
    col_rot  = {col_n[2:0], col_n[3]};
    hit_row  = low_row_index(rows_s);
    hit_col  = col_index(col_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      state     <= ST_SCAN;
      col_n     <= 4'b1110;
      cand_row  <= '0;
      cand_col  <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key_in    <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      slot      <= sample ? '0 : slot + 1'b1;
      key_valid <= 1'b0;
      if (sample) begin
        case (state)
          ST_SCAN: begin
            if (!any_low) begin
              col_n <= col_rot;
            end else begin
              cand_row <= hit_row;
              cand_col <= hit_col;
              deb_cnt  <= DW'(1);
              rel_cnt  <= '0;
              if (DEBOUNCE_CNT == 1) begin
                key_in    <= keymap(hit_row, hit_col);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= ST_HELD;
              end else begin
                state <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (cand_low) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_LIMIT) begin
                key_in    <= keymap(cand_row, cand_col);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                rel_cnt   <= '0;
                state     <= ST_HELD;
              end
            end else begin
              col_n <= col_rot;
              state <= ST_SCAN;
            end
          end
          ST_HELD: begin
            rel_cnt <= rel_next;
            if (rel_next == DEB_LIMIT) begin
              key_down <= 1'b0;
              col_n    <= col_rot;
              state    <= ST_SCAN;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with a keypad matrix model and a sample-level reference model.
module tb_keypad_scan_encoder;

  localparam int S = 4;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_in;
  logic       key_valid;
  logic       key_down;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int col_changes = 0;
  logic [3:0] prev_col = 4'b1110;

  keypad_scan_encoder #(.SCAN_DIV(S), .DEBOUNCE_CNT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_n[c] && pressed[r*4+c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operates on whole slots and plain integers.
  int keymap_tbl [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  logic [3:0] row_edge = 4'hF;
  logic       rst_edge = 1'b0;
  always @(posedge clk) begin
    row_edge <= row_n;
    rst_edge <= rst_n;
  end

  int m_slot, m_phase, m_col, m_row, m_ccol, m_cnt, m_rel, m_key;
  logic [3:0] m_s1, m_s2, rs, exp_col;
  logic m_kv, m_down;

  task automatic model_reset();
    m_slot = 0; m_phase = 0; m_col = 0; m_row = 0; m_ccol = 0;
    m_cnt = 0; m_rel = 0; m_key = 0; m_kv = 0; m_down = 0;
    m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  task automatic model_accept();
    m_key = keymap_tbl[m_row][m_ccol];
    m_kv = 1; m_down = 1; m_rel = 0; m_phase = 2;
  endtask

  task automatic model_step(input logic [3:0] row_in);
    bit smp;
    rs   = m_s2;
    m_s2 = m_s1;
    m_s1 = row_in;
    smp  = (m_slot == S - 1);
    m_slot = (m_slot + 1) % S;
    m_kv = 0;
    if (smp) begin
      if (m_phase == 0) begin
        if (rs == 4'hF) m_col = (m_col + 1) % 4;
        else begin
          m_row = 3;
          for (int r = 3; r >= 0; r--) if (!rs[r]) m_row = r;
          m_ccol = m_col;
          m_cnt = 1;
          if (m_cnt >= D) model_accept(); else m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!rs[m_row]) begin
          m_cnt++;
          if (m_cnt >= D) model_accept();
        end else begin
          m_col = (m_col + 1) % 4;
          m_phase = 0;
        end
      end else begin
        if (rs[m_row]) m_rel++; else m_rel = 0;
        if (m_rel >= D) begin
          m_down = 0;
          m_col = (m_col + 1) % 4;
          m_phase = 0;
        end
      end
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n || !rst_edge) model_reset();
    else model_step(row_edge);
    exp_col = 4'hF;
    exp_col[m_col] = 1'b0;
    check("col_n", 32'(col_n), 32'(exp_col));
    check("key_in", 32'(key_in), 32'(m_key));
    check("key_valid", 32'(key_valid), 32'(m_kv));
    check("key_down", 32'(key_down), 32'(m_down));
    if (key_valid === 1'b1) pulses++;
    if (col_n !== prev_col) col_changes++;
    prev_col = col_n;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic press_release(input logic [15:0] keys, input int hold, input int rel);
    pressed = keys;
    cycles(hold);
    pressed = '0;
    cycles(rel);
  endtask

  int p0, c0;

  initial begin
    cycles(3);
    check("reset col_n", 32'(col_n), 32'h0000000e);
    check("reset key_in", 32'(key_in), 32'h0);
    check("reset key_valid", 32'(key_valid), 32'h0);
    check("reset key_down", 32'(key_down), 32'h0);
    rst_n = 1'b1;

    // Reset while debouncing '2' (column 1 frozen low)
    p0 = pulses;
    pressed = 16'h0002;
    cycles(12);
    check("pre-reset col frozen", 32'(col_n), 32'h0000000d);
    rst_n = 1'b0;
    #1;
    check("async reset col_n", 32'(col_n), 32'h0000000e);
    check("async reset key_valid", 32'(key_valid), 32'h0);
    check("async reset key_down", 32'(key_down), 32'h0);
    pressed = '0;
    cycles(3);
    rst_n = 1'b1;
    cycles(30);
    check("no pulse after reset", 32'(pulses - p0), 32'h0);

    // '6' at r1c2, then re-pressed after full release
    for (int k = 0; k < 2; k++) begin
      p0 = pulses;
      pressed = 16'h0040;
      cycles(40);
      check("6 pulses", 32'(pulses - p0), 32'h1);
      check("6 key_in", 32'(key_in), 32'h6);
      check("6 key_down held", 32'(key_down), 32'h1);
      pressed = '0;
      cycles(40);
      check("6 key_down released", 32'(key_down), 32'h0);
      check("6 key_in kept", 32'(key_in), 32'h6);
    end

    // '+' at r0c3 then enter at r3c3
    p0 = pulses;
    press_release(16'h0008, 40, 40);
    check("+ key_in", 32'(key_in), 32'ha);
    check("+ key_down dropped", 32'(key_down), 32'h0);
    press_release(16'h8000, 40, 40);
    check("enter key_in", 32'(key_in), 32'hd);
    check("+/enter pulses", 32'(pulses - p0), 32'h2);

    // Bouncy '0' at r3c1
    p0 = pulses;
    pressed = 16'h2000; cycles(3);
    pressed = '0;       cycles(3);
    pressed = 16'h2000; cycles(2);
    check("no pulse in bounce", 32'(pulses - p0), 32'h0);
    cycles(40);
    pressed = '0;
    cycles(40);
    check("bounce pulses", 32'(pulses - p0), 32'h1);
    check("bounce key_in", 32'(key_in), 32'h0);

    // r2c0 and r0c0 together, long hold
    p0 = pulses;
    press_release(16'h0101, 50 * S, 40);
    check("priority key_in", 32'(key_in), 32'h1);
    check("long hold pulses", 32'(pulses - p0), 32'h1);

    // Idle scanning
    p0 = pulses;
    c0 = col_changes;
    cycles(16 * S);
    check("idle col rotations", 32'(col_changes - c0), 32'd16);
    check("idle pulses", 32'(pulses - p0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
